// File: rtl/a2d_conv_sched.sv
// Round-robin ADC128S conversion scheduler: runs a command frame, then a data frame,
// through the SPI master for the left, right and battery channels in turn.
module a2d_conv_sched #(
  parameter logic [2:0]  CH_LFT  = 3'd0,
  parameter logic [2:0]  CH_RGHT = 3'd4,
  parameter logic [2:0]  CH_BATT = 3'd5,
  parameter int unsigned TMO_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        conv_vld,
  output logic        busy,
  output logic        tmo_err
);

  localparam int unsigned TW = $clog2(TMO_CYC) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  typedef enum logic [2:0] {IDLE, CMD, WAIT1, GAP, READ, WAIT2, ABORT} state_t;
  typedef enum logic [1:0] {PTR_LFT, PTR_RGHT, PTR_BATT} ptr_t;

  state_t         state, next_state;
  ptr_t           ptr;
  logic           pend;
  logic [TW-1:0]  timer;
  logic [2:0]     ch_c;
  logic           start_c;
  logic           capture_c;
  logic           unused_rd_hi;

  // Upper nibble of the MISO word carries no conversion data.
  assign unused_rd_hi = ^rd_data[15:12];

  // Channel number for the current pointer.
  always_comb begin
    ch_c = CH_LFT;
    unique case (ptr)
      PTR_RGHT: ch_c = CH_RGHT;
      PTR_BATT: ch_c = CH_BATT;
      default:  ch_c = CH_LFT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; timeouts compare against the last allowed timer value.
  always_comb begin
    next_state = state;
    start_c    = 1'b0;
    capture_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (nxt || pend) begin
          next_state = CMD;
          start_c    = 1'b1;
        end
      end
      CMD:   next_state = WAIT1;
      WAIT1: begin
        if (done)                   next_state = GAP;
        else if (timer == TMO_LAST) next_state = ABORT;
      end
      GAP:   next_state = READ;
      READ:  next_state = WAIT2;
      WAIT2: begin
        if (done) begin
          next_state = IDLE;
          capture_c  = 1'b1;
        end else if (timer == TMO_LAST) begin
          next_state = ABORT;
        end
      end
      ABORT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs, request pending flag, frame timer and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrt      <= 1'b0;
      cmd      <= '0;
      busy     <= 1'b0;
      conv_vld <= 1'b0;
      tmo_err  <= 1'b0;
      pend     <= 1'b0;
      timer    <= '0;
      ptr      <= PTR_LFT;
      lft_ld   <= '0;
      rght_ld  <= '0;
      batt     <= '0;
    end else begin
      wrt      <= (next_state == CMD) || (next_state == READ);
      busy     <= (next_state != IDLE);
      conv_vld <= capture_c;
      if (start_c) cmd <= {2'b00, ch_c, 11'h000};
      if (state == ABORT) tmo_err <= 1'b1;
      // IDLE consumes the request; any nxt outside IDLE is held (depth 1).
      if (state == IDLE) pend <= 1'b0;
      else if (nxt)      pend <= 1'b1;
      if ((state == CMD) || (state == READ)) timer <= '0;
      else if (timer != {TW{1'b1}})          timer <= timer + TW'(1);
      if (capture_c) begin
        unique case (ptr)
          PTR_RGHT: begin
            rght_ld <= rd_data[11:0];
            ptr     <= PTR_BATT;
          end
          PTR_BATT: begin
            batt <= rd_data[11:0];
            ptr  <= PTR_LFT;
          end
          default: begin
            lft_ld <= rd_data[11:0];
            ptr    <= PTR_RGHT;
          end
        endcase
      end
    end
  end

endmodule
